// File: rtl/gmii_rx_deframe_pkg.sv
// ---------------------------------------------------------------------------
// gmii_rx_deframe_pkg: shared state encoding and framing/CRC constants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gmii_rx_deframe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRE     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
   // 0x04C11DB7 bit-reversed, for the LSB-first shift form
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

endpackage

`default_nettype wire

// File: rtl/gmii_rx_deframe_crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8: combinational Ethernet CRC-32 next state for one byte, LSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crc32_d8
   import gmii_rx_deframe_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ d[i]) ? CRC_POLY_REFL : 32'h0);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gmii_rx_deframe.sv
// ---------------------------------------------------------------------------
// gmii_rx_deframe: strips preamble/SFD, checks FCS, forwards payload without FCS.
// Optional counters via GMII_RX_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gmii_rx_deframe
   import gmii_rx_deframe_pkg::*;
#(
   parameter int MIN_PRE = 2,
   parameter int LW      = 11
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    d_in,
   input  logic          strobe_in,
   output logic [7:0]    d_out,
   output logic          strobe_out,
   output logic          frame_done,
   output logic          crc_ok,
   output logic          runt,
   output logic [LW-1:0] frame_len
`ifdef GMII_RX_STATS_EN
   ,
   output logic [15:0]   good_cnt,
   output logic [15:0]   bad_crc_cnt,
   output logic [15:0]   drop_cnt
`endif
);

   localparam logic [3:0]    MIN_PRE_C = 4'(MIN_PRE);
   localparam logic [LW-1:0] LEN_MAX   = {LW{1'b1}};

   state_t        state_q, state_d;
   logic [3:0]    pre_cnt_q, pre_cnt_d;
   logic [31:0]   crc_q, crc_d, crc_next;
   logic [31:0]   dly_q, dly_d;
   logic [2:0]    rx_cnt_q, rx_cnt_d;
   logic [LW-1:0] len_q, len_d;
   logic [7:0]    d_out_q, d_out_d;
   logic          strobe_out_q, strobe_out_d;
   logic          frame_done_q, frame_done_d;
   logic          crc_ok_q, crc_ok_d;
   logic          runt_q, runt_d;
   logic [LW-1:0] frame_len_q, frame_len_d;
   logic          drop_evt;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .d       (d_in),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      crc_d        = crc_q;
      dly_d        = dly_q;
      rx_cnt_d     = rx_cnt_q;
      len_d        = len_q;
      d_out_d      = d_out_q;
      strobe_out_d = 1'b0;
      frame_done_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      runt_d       = runt_q;
      frame_len_d  = frame_len_q;
      drop_evt     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (strobe_in) begin
               if (d_in == PREAMBLE_BYTE) begin
                  state_d   = ST_PRE;
                  pre_cnt_d = 4'd1;
               end else begin
                  state_d  = ST_DROP;
                  drop_evt = 1'b1;
               end
            end
         end
         ST_PRE: begin
            if (!strobe_in) begin
               state_d  = ST_IDLE;
               drop_evt = 1'b1;
            end else if (d_in == PREAMBLE_BYTE) begin
               if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
            end else if (d_in == SFD_BYTE && pre_cnt_q >= MIN_PRE_C) begin
               state_d  = ST_PAYLOAD;
               crc_d    = CRC_INIT;
               dly_d    = 32'h0;
               rx_cnt_d = 3'd0;
               len_d    = '0;
            end else begin
               state_d  = ST_DROP;
               drop_evt = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (strobe_in) begin
               crc_d = crc_next;
               dly_d = {dly_q[23:0], d_in};
               // Once four bytes are buffered, the oldest is known not to be FCS
               if (rx_cnt_q == 3'd4) begin
                  d_out_d      = dly_q[31:24];
                  strobe_out_d = 1'b1;
                  if (len_q != LEN_MAX) len_d = len_q + LW'(1);
               end else begin
                  rx_cnt_d = rx_cnt_q + 3'd1;
               end
            end else begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
               runt_d       = (rx_cnt_q != 3'd4);
               crc_ok_d     = (rx_cnt_q == 3'd4) && (crc_q == CRC_RESIDUE);
               frame_len_d  = (rx_cnt_q == 3'd4) ? len_q : '0;
            end
         end
         default: begin
            if (!strobe_in) state_d = ST_IDLE;
         end
      endcase
   end

`ifdef GMII_RX_STATS_EN
   logic [15:0] good_q, bad_q, drop_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pre_cnt_q    <= 4'd0;
         crc_q        <= CRC_INIT;
         dly_q        <= 32'h0;
         rx_cnt_q     <= 3'd0;
         len_q        <= '0;
         d_out_q      <= 8'h0;
         strobe_out_q <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         runt_q       <= 1'b0;
         frame_len_q  <= '0;
`ifdef GMII_RX_STATS_EN
         good_q       <= 16'h0;
         bad_q        <= 16'h0;
         drop_q       <= 16'h0;
`endif
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         crc_q        <= crc_d;
         dly_q        <= dly_d;
         rx_cnt_q     <= rx_cnt_d;
         len_q        <= len_d;
         d_out_q      <= d_out_d;
         strobe_out_q <= strobe_out_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         runt_q       <= runt_d;
         frame_len_q  <= frame_len_d;
`ifdef GMII_RX_STATS_EN
         if (frame_done_d && crc_ok_d)  good_q <= good_q + 16'd1;
         if (frame_done_d && !crc_ok_d) bad_q  <= bad_q + 16'd1;
         if (drop_evt)                  drop_q <= drop_q + 16'd1;
`endif
      end
   end

   assign d_out      = d_out_q;
   assign strobe_out = strobe_out_q;
   assign frame_done = frame_done_q;
   assign crc_ok     = crc_ok_q;
   assign runt       = runt_q;
   assign frame_len  = frame_len_q;
`ifdef GMII_RX_STATS_EN
   assign good_cnt    = good_q;
   assign bad_crc_cnt = bad_q;
   assign drop_cnt    = drop_q;
`endif

endmodule

`default_nettype wire
